// File: rtl/banco_pkg.sv
// Shared constants and helpers for the banco_registradores_sb register bank.
package banco_pkg;

  localparam int unsigned ZERO_IDX = 0;

  // Index width for a bank of n registers.
  function automatic int unsigned addr_width(input int unsigned n);
    return $clog2(n);
  endfunction

  // Low bit of port `port` within a flattened bus of `width`-bit fields.
  function automatic int port_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/banco_scoreboard.sv
// Busy scoreboard: reserve at issue, release on write, and flag stalled reads and WAW reservations.
module banco_scoreboard
  import banco_pkg::*;
#(
  parameter int unsigned NREG     = 32,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned AW       = addr_width(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREAD*AW-1:0] ra,
  input  logic                we,
  input  logic [AW-1:0]       rw,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_reg,
  output logic [NREG-1:0]     busy,
  output logic [NREAD-1:0]    rd_busy,
  output logic                waw
);

  logic [NREG-1:0] busy_nxt;
  logic            rsv_ok;

  assign rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_reg == AW'(ZERO_IDX)));

  // Release first, then reserve, so a same-register reservation wins.
  always_comb begin
    busy_nxt = busy;
    if (we) busy_nxt[rw] = 1'b0;
    if (rsv_ok) busy_nxt[rsv_reg] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  assign waw = rsv_en && busy[rsv_reg] && !(we && (rw == rsv_reg));

  for (genvar i = 0; i < int'(NREAD); i++) begin : g_rdb
    logic [AW-1:0] a;
    logic          fwd;
    logic          zr;
    assign a   = ra[port_lo(i, int'(AW)) +: AW];
    assign fwd = (BYPASS != 0) && we && (rw == a);
    assign zr  = (ZERO_REG != 0) && (a == AW'(ZERO_IDX));
    assign rd_busy[i] = busy[a] && !fwd && !zr;
  end

endmodule

// File: rtl/banco_registradores_sb.sv
// Parametrised register bank with combinational read ports, write bypass and busy scoreboard.
module banco_registradores_sb
  import banco_pkg::*;
#(
  parameter int unsigned BITS     = 64,
  parameter int unsigned NREG     = 32,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned AW       = addr_width(NREG)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREAD*AW-1:0]   ra,
  output logic [NREAD*BITS-1:0] dout,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  we,
  input  logic [AW-1:0]         rw,
  input  logic [BITS-1:0]       din,
  input  logic                  rsv_en,
  input  logic [AW-1:0]         rsv_reg,
  output logic [NREG-1:0]       busy,
  output logic                  waw
);

  logic [BITS-1:0] regs [NREG];
  logic            wr_ok;

  // Writes to a hardwired zero register are dropped entirely, including for bypass.
  assign wr_ok = we && !((ZERO_REG != 0) && (rw == AW'(ZERO_IDX)));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < int'(NREG); r++) regs[r] <= '0;
    end else if (wr_ok) begin
      regs[rw] <= din;
    end
  end

  for (genvar i = 0; i < int'(NREAD); i++) begin : g_rd
    logic [AW-1:0]   a;
    logic [BITS-1:0] q;
    assign a = ra[port_lo(i, int'(AW)) +: AW];
    always_comb begin
      q = regs[a];
      if ((ZERO_REG != 0) && (a == AW'(ZERO_IDX))) q = '0;
      else if ((BYPASS != 0) && wr_ok && (rw == a)) q = din;
    end
    assign dout[port_lo(i, int'(BITS)) +: BITS] = q;
  end

  banco_scoreboard #(
    .NREG     (NREG),
    .NREAD    (NREAD),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS),
    .AW       (AW)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .ra      (ra),
    .we      (we),
    .rw      (rw),
    .rsv_en  (rsv_en),
    .rsv_reg (rsv_reg),
    .busy    (busy),
    .rd_busy (rd_busy),
    .waw     (waw)
  );

endmodule

// File: tb/tb_banco_registradores_sb.sv
// Directed bench for banco_registradores_sb: default instance plus a 3-port, 32-bit, no-bypass instance.
module tb_banco_registradores_sb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default configuration: BITS=64, NREG=32, NREAD=2, ZERO_REG=1, BYPASS=1.
  logic [9:0]   ra;
  logic [127:0] dout;
  logic [1:0]   rd_busy;
  logic         we;
  logic [4:0]   rw;
  logic [63:0]  din;
  logic         rsv_en;
  logic [4:0]   rsv_reg;
  logic [31:0]  busy;
  logic         waw;

  // Sweep configuration: BITS=32, NREG=16, NREAD=3, BYPASS=0.
  logic [11:0]  ra2;
  logic [95:0]  dout2;
  logic [2:0]   rd_busy2;
  logic         we2;
  logic [3:0]   rw2;
  logic [31:0]  din2;
  logic         rsv_en2;
  logic [3:0]   rsv_reg2;
  logic [15:0]  busy2;
  logic         waw2;

  int checks = 0;
  int errors = 0;

  banco_registradores_sb dut (
    .clk(clk), .rst(rst), .ra(ra), .dout(dout), .rd_busy(rd_busy),
    .we(we), .rw(rw), .din(din), .rsv_en(rsv_en), .rsv_reg(rsv_reg),
    .busy(busy), .waw(waw)
  );

  banco_registradores_sb #(.BITS(32), .NREG(16), .NREAD(3), .ZERO_REG(1), .BYPASS(0)) dut2 (
    .clk(clk), .rst(rst), .ra(ra2), .dout(dout2), .rd_busy(rd_busy2),
    .we(we2), .rw(rw2), .din(din2), .rsv_en(rsv_en2), .rsv_reg(rsv_reg2),
    .busy(busy2), .waw(waw2)
  );

  task automatic idle();
    we = 1'b0; rw = '0; din = '0; rsv_en = 1'b0; rsv_reg = '0;
    we2 = 1'b0; rw2 = '0; din2 = '0; rsv_en2 = 1'b0; rsv_reg2 = '0;
  endtask

  task automatic test_reset();
    @(negedge clk); we = 1'b1; rw = 5'd3; din = 64'h5;
    @(negedge clk); rw = 5'd4; din = 64'h6; rsv_en = 1'b1; rsv_reg = 5'd10;
    we2 = 1'b1; rw2 = 4'd3; din2 = 32'h1234; rsv_en2 = 1'b1; rsv_reg2 = 4'd6;
    // Reset cycle with a write and reservation that must be dropped.
    @(negedge clk); rst = 1'b1; rw = 5'd3; din = 64'd77; rsv_reg = 5'd11;
    @(negedge clk); rst = 1'b0; idle();
    #1;
    checks++;
    if (busy !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h expected %h", busy, 32'h0); end
    checks++;
    if (waw !== 1'b0) begin errors++; $display("FAIL reset_waw: got %b expected 0", waw); end
    checks++;
    if (busy2 !== 16'h0) begin errors++; $display("FAIL reset_busy2: got %h expected 0", busy2); end
    for (int r = 0; r < 32; r++) begin
      ra = {5'd0, 5'(r)};
      #1;
      checks++;
      if (dout[63:0] !== 64'h0 || rd_busy !== 2'b00)
        begin errors++; $display("FAIL reset_read r%0d: dout %h busy %b expected 0 0", r, dout[63:0], rd_busy); end
    end
    for (int r = 0; r < 16; r++) begin
      ra2 = {4'(r), 4'(r), 4'(r)};
      #1;
      checks++;
      if (dout2 !== 96'h0 || rd_busy2 !== 3'b000)
        begin errors++; $display("FAIL reset_read2 r%0d: dout %h busy %b expected 0 0", r, dout2, rd_busy2); end
    end
  endtask

  task automatic test_bypass();
    @(negedge clk); we = 1'b1; rw = 5'd5; din = 64'hDEAD_BEEF; ra = {5'd6, 5'd5};
    #1;
    checks++;
    if (dout[63:0] !== 64'hDEAD_BEEF) begin errors++; $display("FAIL bypass_same_cycle: got %h expected %h", dout[63:0], 64'hDEAD_BEEF); end
    checks++;
    if (dout[127:64] !== 64'h0) begin errors++; $display("FAIL bypass_other_port: got %h expected 0", dout[127:64]); end
    @(negedge clk); we = 1'b0; din = 64'h1111;
    #1;
    checks++;
    if (dout[63:0] !== 64'hDEAD_BEEF) begin errors++; $display("FAIL bypass_stored: got %h expected %h", dout[63:0], 64'hDEAD_BEEF); end
  endtask

  task automatic test_zero_reg();
    @(negedge clk); we = 1'b1; rw = 5'd0; din = '1; rsv_en = 1'b1; rsv_reg = 5'd0; ra = {5'd0, 5'd0};
    #1;
    checks++;
    if (dout[63:0] !== 64'h0) begin errors++; $display("FAIL x0_bypass: got %h expected 0", dout[63:0]); end
    @(posedge clk); #1;
    checks++;
    if (busy[0] !== 1'b0) begin errors++; $display("FAIL x0_busy: got %b expected 0", busy[0]); end
    checks++;
    if (waw !== 1'b0) begin errors++; $display("FAIL x0_waw: got %b expected 0", waw); end
    @(negedge clk); idle();
    #1;
    checks++;
    if (dout[63:0] !== 64'h0 || rd_busy[0] !== 1'b0)
      begin errors++; $display("FAIL x0_stored: dout %h busy %b expected 0 0", dout[63:0], rd_busy[0]); end
  endtask

  task automatic test_scoreboard();
    @(negedge clk); rsv_en = 1'b1; rsv_reg = 5'd7; ra = {5'd5, 5'd7};
    @(negedge clk); idle();
    #1;
    checks++;
    if (busy !== 32'h0000_0080) begin errors++; $display("FAIL sb_reserve: got %h expected %h", busy, 32'h80); end
    checks++;
    if (rd_busy !== 2'b01) begin errors++; $display("FAIL sb_rd_busy: got %b expected 01", rd_busy); end
    @(negedge clk); we = 1'b1; rw = 5'd7; din = 64'h42;
    #1;
    checks++;
    if (rd_busy[0] !== 1'b0 || dout[63:0] !== 64'h42)
      begin errors++; $display("FAIL sb_release_fwd: busy %b dout %h expected 0 42", rd_busy[0], dout[63:0]); end
    @(posedge clk); #1;
    checks++;
    if (busy !== 32'h0) begin errors++; $display("FAIL sb_release: got %h expected 0", busy); end
    // Write and reserve different registers in the same cycle.
    @(negedge clk); we = 1'b1; rw = 5'd3; din = 64'h33; rsv_en = 1'b1; rsv_reg = 5'd4; ra = {5'd4, 5'd3};
    @(negedge clk); idle();
    #1;
    checks++;
    if (busy !== 32'h0000_0010) begin errors++; $display("FAIL sb_split_busy: got %h expected %h", busy, 32'h10); end
    checks++;
    if (dout[63:0] !== 64'h33 || rd_busy !== 2'b10)
      begin errors++; $display("FAIL sb_split_read: dout %h busy %b expected 33 10", dout[63:0], rd_busy); end
    @(negedge clk); we = 1'b1; rw = 5'd4; din = 64'h0;
    @(negedge clk); idle();
  endtask

  task automatic test_back_to_back();
    @(negedge clk); rsv_en = 1'b1; rsv_reg = 5'd9; ra = {5'd0, 5'd9};
    @(negedge clk); we = 1'b1; rw = 5'd9; din = 64'h99;
    #1;
    checks++;
    if (waw !== 1'b0) begin errors++; $display("FAIL waw_same_reg: got %b expected 0", waw); end
    @(negedge clk); we = 1'b0; din = '0;
    #1;
    checks++;
    if (busy[9] !== 1'b1 || dout[63:0] !== 64'h99)
      begin errors++; $display("FAIL waw_write_kept: busy %b dout %h expected 1 99", busy[9], dout[63:0]); end
    checks++;
    if (waw !== 1'b1) begin errors++; $display("FAIL waw_busy_reg: got %b expected 1", waw); end
    checks++;
    if (rd_busy[0] !== 1'b1) begin errors++; $display("FAIL waw_rd_busy: got %b expected 1", rd_busy[0]); end
    @(negedge clk); idle();
    #1;
    checks++;
    if (waw !== 1'b0 || busy !== 32'h0000_0200)
      begin errors++; $display("FAIL waw_idle: waw %b busy %h expected 0 00000200", waw, busy); end
  endtask

  task automatic test_no_bypass();
    @(negedge clk); we2 = 1'b1; rw2 = 4'd2; din2 = 32'd11;
    @(negedge clk); rw2 = 4'd5; din2 = 32'd22;
    @(negedge clk); rw2 = 4'd9; din2 = 32'd33; rsv_en2 = 1'b1; rsv_reg2 = 4'd5;
    @(negedge clk); we2 = 1'b0; rsv_en2 = 1'b0; ra2 = {4'd9, 4'd5, 4'd2};
    #1;
    checks++;
    if (dout2 !== {32'd33, 32'd22, 32'd11}) begin errors++; $display("FAIL nb_ports: got %h expected %h", dout2, {32'd33, 32'd22, 32'd11}); end
    @(negedge clk); we2 = 1'b1; rw2 = 4'd5; din2 = 32'hAAAA;
    #1;
    checks++;
    if (dout2 !== {32'd33, 32'd22, 32'd11}) begin errors++; $display("FAIL nb_not_forwarded: got %h expected %h", dout2, {32'd33, 32'd22, 32'd11}); end
    checks++;
    if (rd_busy2 !== 3'b010) begin errors++; $display("FAIL nb_rd_busy: got %b expected 010", rd_busy2); end
    @(posedge clk); #1;
    checks++;
    if (dout2 !== {32'd33, 32'hAAAA, 32'd11}) begin errors++; $display("FAIL nb_after_edge: got %h expected %h", dout2, {32'd33, 32'hAAAA, 32'd11}); end
    checks++;
    if (busy2 !== 16'h0 || rd_busy2 !== 3'b000)
      begin errors++; $display("FAIL nb_release: busy %h rd_busy %b expected 0 0", busy2, rd_busy2); end
    @(negedge clk); idle();
  endtask

  initial begin
    rst = 1'b1; ra = '0; ra2 = '0; idle();
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    test_reset();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_back_to_back();
    test_no_bypass();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
